// File: rtl/spi_pkg.sv
// Shared SPI master types and defaults.
// Latency: none (declarations only).
// Backpressure: none.
package spi_pkg;

  // Transfer sequencer states; LOW/HIGH/TAIL each last one sclk half-period
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    TAIL = 2'd3
  } state_t;

  localparam int DWIDTH_DEF      = 8;
  localparam int HALF_PERIOD_DEF = 1;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period timer: emits a one-clk phase_end tick every HALF_PERIOD clks while enabled.
// Latency: first tick HALF_PERIOD clks after clr/enable.
// Backpressure: none; free-running while en is high, restarts on clr.
module spi_clkdiv
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic phase_end
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == LAST);

  // Count clks within the current half-period, wrapping on the tick
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= phase_end ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_core.sv
// SPI mode-0 master: one full-duplex MSB-first DWIDTH-bit transfer per host write.
// Latency: done/dout update (2*DWIDTH+1)*HALF_PERIOD clks after the accepting write.
// Backpressure: writes while busy are dropped; done holds until read, new write or reset.
module spi_core
  import spi_pkg::*;
#(
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic              done
);

  localparam int BW = $clog2(DWIDTH + 1);

  state_t            state;
  logic [DWIDTH-1:0] tx;
  logic [DWIDTH-1:0] rx;
  logic [BW-1:0]     bitcnt;
  logic              phase_end;
  logic              start;
  logic              rd_ack;

  // Host strobes only act in IDLE; a read wins over a simultaneous write
  assign start  = (state == IDLE) && cs && wr && !rd;
  assign rd_ack = (state == IDLE) && cs && rd;

  spi_clkdiv #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clkdiv (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .en       (state != IDLE),
    .phase_end(phase_end)
  );

  // Transfer sequencer with shift registers and registered SPI/host outputs.
  // miso is sampled at the end of a low phase, one half-period after the
  // falling edge that launched it; the first low phase has nothing to sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      dout   <= '0;
      done   <= 1'b0;
      tx     <= '0;
      rx     <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_ack) begin
            done <= 1'b0;
          end else if (start) begin
            tx     <= din;
            mosi   <= din[DWIDTH-1];
            rx     <= '0;
            bitcnt <= '0;
            done   <= 1'b0;
            state  <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            if (bitcnt != '0) begin
              rx <= {rx[DWIDTH-2:0], miso};
            end
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            sclk   <= 1'b0;
            tx     <= {tx[DWIDTH-2:0], 1'b0};
            mosi   <= tx[DWIDTH-2];
            bitcnt <= bitcnt + BW'(1);
            state  <= (bitcnt == BW'(DWIDTH - 1)) ? TAIL : LOW;
          end
        end
        TAIL: begin
          if (phase_end) begin
            dout  <= {rx[DWIDTH-2:0], miso};
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_core.sv
// Bench for spi_core: two instances (8-bit/half-period 1 and 16-bit/half-period 3),
// each wired to a behavioural SPI secondary that samples mosi on sclk rise and
// shifts out its MSB on sclk fall.
module tb_spi_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cs, rd, wr;
  logic [7:0]  din, dout;
  logic        miso, mosi, sclk, done;

  logic        b_cs, b_rd, b_wr;
  logic [15:0] b_din, b_dout;
  logic        b_miso, b_mosi, b_sclk, b_done;

  int checks = 0;
  int errors = 0;

  spi_core #(.DWIDTH(8), .HALF_PERIOD(1)) dut_a (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .din(din), .dout(dout),
    .miso(miso), .mosi(mosi), .sclk(sclk), .done(done)
  );

  spi_core #(.DWIDTH(16), .HALF_PERIOD(3)) dut_b (
    .clk(clk), .rst(rst), .cs(b_cs), .rd(b_rd), .wr(b_wr), .din(b_din), .dout(b_dout),
    .miso(b_miso), .mosi(b_mosi), .sclk(b_sclk), .done(b_done)
  );

  // Secondary for instance A
  logic       ld_a = 1'b0;
  logic [7:0] ld_a_val = '0;
  logic [7:0] sec_a;
  logic       cap_a, sclk_a_q;
  int         rises_a;

  always @(negedge clk) begin
    if (ld_a) begin
      sec_a    <= ld_a_val;
      miso     <= 1'b0;
      rises_a  <= 0;
      sclk_a_q <= sclk;
    end else begin
      if (sclk && !sclk_a_q) begin
        cap_a   <= mosi;
        rises_a <= rises_a + 1;
      end
      if (!sclk && sclk_a_q) begin
        miso  <= sec_a[7];
        sec_a <= {sec_a[6:0], cap_a};
      end
      sclk_a_q <= sclk;
    end
  end

  // Secondary for instance B
  logic        ld_b = 1'b0;
  logic [15:0] ld_b_val = '0;
  logic [15:0] sec_b;
  logic        cap_b, sclk_b_q;
  int          rises_b;

  always @(negedge clk) begin
    if (ld_b) begin
      sec_b    <= ld_b_val;
      b_miso   <= 1'b0;
      rises_b  <= 0;
      sclk_b_q <= b_sclk;
    end else begin
      if (b_sclk && !sclk_b_q) begin
        cap_b   <= b_mosi;
        rises_b <= rises_b + 1;
      end
      if (!b_sclk && sclk_b_q) begin
        b_miso <= sec_b[15];
        sec_b  <= {sec_b[14:0], cap_b};
      end
      sclk_b_q <= b_sclk;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic reload_a(input logic [7:0] v);
    @(posedge clk); #1;
    ld_a_val = v; ld_a = 1'b1;
    @(posedge clk); #1;
    ld_a = 1'b0;
  endtask

  task automatic reload_b(input logic [15:0] v);
    @(posedge clk); #1;
    ld_b_val = v; ld_b = 1'b1;
    @(posedge clk); #1;
    ld_b = 1'b0;
  endtask

  // Write d to instance A and wait for done; optionally re-write inj at clk inj_at.
  // lat is the number of clk edges from the accepting edge to done.
  task automatic run_a(input logic [7:0] d, input int inj_at, input logic [7:0] inj,
                       output int lat);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; din = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; din = 8'($urandom);
    chk("done_clear_on_start", {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 300) begin
      if (inj_at > 0 && lat == inj_at - 1) begin
        cs = 1'b1; wr = 1'b1; din = inj;
      end
      @(negedge clk);
      lat++;
      cs = 1'b0; wr = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] pre;
    logic [7:0] exp_dout;
    logic [7:0] exp_sec;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   lat;
    int   r0;
    logic [7:0] pre, d;

    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; din = '0;
    b_cs = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_din = '0;
    reload_a(8'h00);
    reload_b(16'h0000);

    // 1: reset state, strobes during reset ignored
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; din = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0; cs = 1'b0; wr = 1'b0;
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_start", rises_a, 0);

    // 2: basic transfer
    reload_a(8'h3C);
    run_a(8'hAA, 0, 8'h00, lat);
    chk("t2_latency", lat, 17);
    chk("t2_dout", {24'd0, dout}, 32'h3C);
    chk("t2_sec", {24'd0, sec_a}, 32'hAA);
    chk("t2_pulses", rises_a, 8);

    // done holds without a read
    repeat (4) @(negedge clk);
    chk("done_hold", {31'd0, done}, 32'd1);

    // 3: read acknowledges, then next transfer
    @(negedge clk); cs = 1'b1; rd = 1'b1;
    @(negedge clk); cs = 1'b0; rd = 1'b0;
    chk("t3_read_done", {31'd0, done}, 32'd0);
    chk("t3_read_dout", {24'd0, dout}, 32'h3C);
    run_a(8'h55, 0, 8'h00, lat);
    chk("t3_dout", {24'd0, dout}, 32'hAA);
    chk("t3_sec", {24'd0, sec_a}, 32'h55);

    // 4: write while busy is ignored
    reload_a(8'h55);
    run_a(8'h0F, 5, 8'hF0, lat);
    chk("t4_latency", lat, 17);
    chk("t4_dout", {24'd0, dout}, 32'h55);
    chk("t4_sec", {24'd0, sec_a}, 32'h0F);
    chk("t4_pulses", rises_a, 8);

    // simultaneous read and write: read acts, no transfer starts
    r0 = rises_a;
    @(negedge clk); cs = 1'b1; rd = 1'b1; wr = 1'b1; din = 8'hFF;
    @(negedge clk); cs = 1'b0; rd = 1'b0; wr = 1'b0;
    chk("rdwr_done", {31'd0, done}, 32'd0);
    repeat (4) @(negedge clk);
    chk("rdwr_no_start", rises_a, r0);
    chk("rdwr_dout", {24'd0, dout}, 32'h55);

    // 5: reset mid-transfer at clk 9
    @(negedge clk); cs = 1'b1; wr = 1'b1; din = 8'h99;
    @(negedge clk); cs = 1'b0; wr = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_sclk", {31'd0, sclk}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_dout", {24'd0, dout}, 32'd0);
    reload_a(8'h5A);
    repeat (2) @(negedge clk);
    chk("t5_idle_after_rst", rises_a, 0);
    run_a(8'hC3, 0, 8'h00, lat);
    chk("t5_latency", lat, 17);
    chk("t5_dout2", {24'd0, dout}, 32'h5A);
    chk("t5_sec", {24'd0, sec_a}, 32'hC3);

    // table-driven vectors: dout = word preloaded in the secondary, secondary ends with din
    vecs[0] = '{din: 8'h00, pre: 8'hFF, exp_dout: 8'hFF, exp_sec: 8'h00};
    vecs[1] = '{din: 8'hFF, pre: 8'h00, exp_dout: 8'h00, exp_sec: 8'hFF};
    vecs[2] = '{din: 8'h81, pre: 8'h7E, exp_dout: 8'h7E, exp_sec: 8'h81};
    vecs[3] = '{din: 8'h01, pre: 8'h80, exp_dout: 8'h80, exp_sec: 8'h01};
    for (int i = 0; i < 4; i++) begin
      reload_a(vecs[i].pre);
      run_a(vecs[i].din, 0, 8'h00, lat);
      chk($sformatf("vec%0d_latency", i), lat, 17);
      chk($sformatf("vec%0d_dout", i), {24'd0, dout}, {24'd0, vecs[i].exp_dout});
      chk($sformatf("vec%0d_sec", i), {24'd0, sec_a}, {24'd0, vecs[i].exp_sec});
    end

    // randomized transfers against the reference rules
    for (int i = 0; i < 8; i++) begin
      pre = 8'($urandom);
      d   = 8'($urandom);
      reload_a(pre);
      run_a(d, 0, 8'h00, lat);
      chk($sformatf("rnd%0d_latency", i), lat, (2 * 8 + 1) * 1);
      chk($sformatf("rnd%0d_dout", i), {24'd0, dout}, {24'd0, pre});
      chk($sformatf("rnd%0d_sec", i), {24'd0, sec_a}, {24'd0, d});
      chk($sformatf("rnd%0d_pulses", i), rises_a, 8);
    end

    // 6: 16-bit, half-period 3
    begin
      int  run, bad;
      logic prev, s, seen_rise;
      reload_b(16'h1234);
      @(negedge clk); b_cs = 1'b1; b_wr = 1'b1; b_din = 16'hA5F0;
      @(negedge clk); b_cs = 1'b0; b_wr = 1'b0;
      lat = 0; run = 1; bad = 0; prev = 1'b0; seen_rise = 1'b0;
      while (!b_done && lat < 1000) begin
        @(negedge clk);
        lat++;
        s = b_sclk;
        if (s != prev) begin
          if (prev || seen_rise) begin
            if (run != 3) bad++;
          end
          if (s) seen_rise = 1'b1;
          run = 1;
        end else begin
          run++;
        end
        prev = s;
      end
      chk("t6_latency", lat, (2 * 16 + 1) * 3);
      chk("t6_dout", {16'd0, b_dout}, 32'h1234);
      chk("t6_sec", {16'd0, sec_b}, 32'hA5F0);
      chk("t6_pulses", rises_b, 16);
      chk("t6_phase_len_errs", bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
